// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for an external FIFO memory array.
// The block turns push/pop requests into memory write/read enables and
// addresses. It also tracks occupancy, decodes full/empty/almost flags and
// reports overflow/underflow. The memory data path is outside this block.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high; takes priority over push/pop
//   push, pop     write / read requests
//   write_enable  push & ~full (combinational)
//   read_enable   pop & ~empty (combinational)
//   write_addr    zero-extended write pointer (4 bits)
//   read_addr     zero-extended read pointer (4 bits)
//   data_valid    memory read data valid, one cycle after an accepted pop
//   full, empty   occupancy == DEPTH / occupancy == 0
//   almost_full   occupancy >= AF_TH
//   almost_empty  occupancy <= AE_TH
//   fifo_count    occupancy 0..DEPTH
//   overflow      registered: a push was made while full
//   underflow     registered: a pop was made while empty
//
// Build option FIFO_ERR_STICKY_EN: when it is defined, overflow and underflow
// stay high until reset. When it is not defined, each offending request gives
// a single-cycle pulse.
// ADDR_WIDTH must be <= 4 so that the pointers fit the 4-bit address ports.

module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_TH      = 6,
    parameter int unsigned AE_TH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [3:0]            write_addr,
    output logic [3:0]            read_addr,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfThC  = CW'(AF_TH);
    localparam logic [CW-1:0] AeThC  = CW'(AE_TH);

    typedef enum logic [1:0] {
        StEmpty,
        StActive,
        StFull
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  data_valid_q, data_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    // Flags come only from registered state. They never see this cycle's
    // requests.
    assign full         = (state_q == StFull);
    assign empty        = (state_q == StEmpty);
    assign almost_full  = (count_q >= AfThC);
    assign almost_empty = (count_q <= AeThC);

    // Gating acceptance on the flags handles the push+pop corner cases.
    // When empty, only the push is taken. When full, only the pop is taken.
    // There is no read-through-write.
    assign wr_acc = push & ~full;
    assign rd_acc = pop & ~empty;

    assign write_enable = wr_acc;
    assign read_enable  = rd_acc;
    assign write_addr   = 4'(wr_ptr_q);
    assign read_addr    = 4'(rd_ptr_q);
    assign fifo_count   = count_q;
    assign data_valid   = data_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        // Pointers wrap for free because DEPTH is a power of two.
        wr_ptr_d     = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d     = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        // Gated acceptance keeps the count within 0..DEPTH, so no clamp is needed.
        count_d      = count_q + CW'(wr_acc) - CW'(rd_acc);
        data_valid_d = rd_acc;
`ifdef FIFO_ERR_STICKY_EN
        overflow_d   = overflow_q | (push & full);
        underflow_d  = underflow_q | (pop & empty);
`else
        overflow_d   = push & full;
        underflow_d  = pop & empty;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (wr_acc) begin
                    state_d = (count_d == DepthC) ? StFull : StActive;
                end
            end
            StActive: begin
                if (count_d == DepthC) begin
                    state_d = StFull;
                end else if (count_d == '0) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (rd_acc) begin
                    state_d = StActive;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StEmpty;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed, table-driven bench for fifo_ctrl with default
// parameters (DEPTH 8, AF_TH 6, AE_TH 2).
// Each table row holds the inputs for one cycle. It also holds the outputs
// expected while those inputs are applied, before the next rising edge.
// Registered outputs show the effect of earlier edges. The enables show the
// current inputs.

module tb_fifo_ctrl;

    typedef struct {
        logic       rst, psh, pp;
        logic       we, re;
        logic [3:0] wa, ra;
        logic       dv, full, empty, af, ae;
        logic [3:0] cnt;
        logic       ovf, unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, push, pop;
    logic       write_enable, read_enable, data_valid;
    logic [3:0] write_addr, read_addr, fifo_count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .write_addr   (write_addr),
        .read_addr    (read_addr),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int r, input int ps, input int pp, input int we, input int re,
                       input int wa, input int ra, input int dv, input int fu, input int em,
                       input int af, input int ae, input int cnt, input int ov, input int un);
        vec_t v;
        v.rst = r[0];   v.psh = ps[0];  v.pp = pp[0];
        v.we = we[0];   v.re = re[0];
        v.wa = wa[3:0]; v.ra = ra[3:0];
        v.dv = dv[0];   v.full = fu[0]; v.empty = em[0];
        v.af = af[0];   v.ae = ae[0];   v.cnt = cnt[3:0];
        v.ovf = ov[0];  v.unf = un[0];
        vecs.push_back(v);
    endtask

    initial begin
        logic ovf_lat;
        logic unf_lat;
        logic exp_ovf;
        logic exp_unf;
        ovf_lat = 1'b0;
        unf_lat = 1'b0;

        // 1: state right after reset
        add(0,0,0, 0,0,0,0, 0,0,1,0,1, 0, 0,0);
        // 2: fill with 8 pushes, then push while full
        for (int k = 0; k < 8; k++)
            add(0,1,0, 1,0,k,0, 0,0,int'(k == 0),int'(k >= 6),int'(k <= 2), k, 0,0);
        add(0,1,0, 0,0,0,0, 0,1,0,1,0, 8, 0,0);
        add(0,0,0, 0,0,0,0, 0,1,0,1,0, 8, 1,0);
        // 3: drain with 8 pops, then pop while empty
        for (int k = 0; k < 8; k++)
            add(0,0,1, 0,1,0,k, int'(k > 0),int'(k == 0),0,int'(k <= 2),int'(k >= 6),
                8 - k, 0,0);
        add(0,0,1, 0,0,0,0, 1,0,1,0,1, 0, 0,0);
        add(0,0,0, 0,0,0,0, 0,0,1,0,1, 0, 0,1);
        add(0,0,0, 0,0,0,0, 0,0,1,0,1, 0, 0,0);
        // 5a: push+pop while empty takes only the push and flags underflow
        add(0,1,1, 1,0,0,0, 0,0,1,0,1, 0, 0,0);
        add(0,1,0, 1,0,1,0, 0,0,0,0,1, 1, 0,1);
        add(0,1,0, 1,0,2,0, 0,0,0,0,1, 2, 0,0);
        add(0,1,0, 1,0,3,0, 0,0,0,0,0, 3, 0,0);
        // 4: steady push+pop at count 4, both pointers wrap
        for (int i = 0; i < 20; i++)
            add(0,1,1, 1,1,(4 + i) % 8,i % 8, int'(i > 0),0,0,0,0, 4, 0,0);
        add(0,0,0, 0,0,0,4, 1,0,0,0,0, 4, 0,0);
        // refill to full
        for (int j = 0; j < 4; j++)
            add(0,1,0, 1,0,j,4, 0,0,0,int'(j >= 2),0, 4 + j, 0,0);
        // 5b: push+pop while full takes only the pop and flags overflow
        add(0,1,1, 0,1,4,4, 0,1,0,1,0, 8, 0,0);
        add(0,0,0, 0,0,4,5, 1,0,0,1,0, 7, 1,0);
        // 6: pop down to 5, then reset during push+pop traffic
        add(0,0,1, 0,1,4,5, 0,0,0,1,0, 7, 0,0);
        add(0,0,1, 0,1,4,6, 1,0,0,1,0, 6, 0,0);
        add(1,1,1, 1,1,4,7, 1,0,0,0,0, 5, 0,0);
        add(0,0,0, 0,0,0,0, 0,0,1,0,1, 0, 0,0);
        add(0,1,0, 1,0,0,0, 0,0,1,0,1, 0, 0,0);
        add(0,0,0, 0,0,1,0, 0,0,0,0,1, 1, 0,0);

        // Reset held with push asserted: reset must take priority.
        reset = 1'b1; push = 1'b1; pop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push = 1'b0;
        #1;
        chk("reset_wins_count", -1, fifo_count, 4'd0);
        chk("reset_wins_empty", -1, {3'b0, empty}, 4'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            push  = vecs[i].psh;
            pop   = vecs[i].pp;
            #1;
`ifdef FIFO_ERR_STICKY_EN
            ovf_lat = ovf_lat | vecs[i].ovf;
            unf_lat = unf_lat | vecs[i].unf;
            exp_ovf = ovf_lat;
            exp_unf = unf_lat;
`else
            exp_ovf = vecs[i].ovf;
            exp_unf = vecs[i].unf;
`endif
            chk("write_enable", i, {3'b0, write_enable}, {3'b0, vecs[i].we});
            chk("read_enable",  i, {3'b0, read_enable},  {3'b0, vecs[i].re});
            chk("write_addr",   i, write_addr,           vecs[i].wa);
            chk("read_addr",    i, read_addr,            vecs[i].ra);
            chk("data_valid",   i, {3'b0, data_valid},   {3'b0, vecs[i].dv});
            chk("full",         i, {3'b0, full},         {3'b0, vecs[i].full});
            chk("empty",        i, {3'b0, empty},        {3'b0, vecs[i].empty});
            chk("almost_full",  i, {3'b0, almost_full},  {3'b0, vecs[i].af});
            chk("almost_empty", i, {3'b0, almost_empty}, {3'b0, vecs[i].ae});
            chk("fifo_count",   i, fifo_count,           vecs[i].cnt);
            chk("overflow",     i, {3'b0, overflow},     {3'b0, exp_ovf});
            chk("underflow",    i, {3'b0, underflow},    {3'b0, exp_unf});
            if (vecs[i].rst) begin
                ovf_lat = 1'b0;
                unf_lat = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
